response_id_restore_unit: RTL and testbench

RESPONSE_ID_RESTORE_UNIT -- requirements
Module: response_id_restore_unit

---
 rtl/response_id_restore_unit.sv | 163 ++++++++++++++++
 tb/tb_response_id_restore_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/response_id_restore_unit.sv
// response_id_restore_unit
//   Restores original IDs on read-response beats coming back from the slave side,
//   buffers them in a small circular FIFO and replays them in order on the master side.
//   Each beat's unique ID is released to the allocator on its last beat.
//   A two-state burst tracker flags (sticky) any ID change in the middle of a burst.
//   Optional feature macro: RSP_ERR_COUNT_EN adds an 8-bit saturating count of
//   accepted beats whose s_rresp is not OKAY (err_count output).
module response_id_restore_unit #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // slave side
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [ID_WIDTH-1:0]   s_rid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  // allocator
  output logic [ID_WIDTH-1:0]   unique_id_to_free,
  output logic                  free_req,
  input  logic [ID_WIDTH-1:0]   restored_id,
  // master side
  output logic                  m_rvalid,
  input  logic                  m_rready,
  output logic [ID_WIDTH-1:0]   m_rid,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic [1:0]            m_rresp,
  output logic                  m_rlast,
  output logic                  protocol_err
`ifdef RSP_ERR_COUNT_EN
  ,
  output logic [7:0]            err_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } beat_t;

  beat_t [FIFO_DEPTH-1:0] mem_q;
  logic  [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic  [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic  [CNT_W-1:0]      cnt_q, cnt_d;
  logic  [0:0]            state_q, state_d;
  logic  [ID_WIDTH-1:0]   burst_id_q, burst_id_d;
  logic                   perr_q, perr_d;

  logic  full, empty, push, pop;
  beat_t head;
  beat_t wr_beat;

  // Occupancy flags and handshakes; s_rready depends only on registered state
  always_comb begin
    full     = (cnt_q == CNT_W'(FIFO_DEPTH));
    empty    = (cnt_q == '0);
    push     = s_rvalid & ~full;
    pop      = ~empty & m_rready;
    wr_beat  = '{id: restored_id, data: s_rdata, resp: s_rresp, last: s_rlast};
    head     = mem_q[rd_ptr_q];
  end

  assign s_rready          = ~full;
  assign unique_id_to_free = s_rid;
  assign free_req          = push & s_rlast;

  // Head entry is gated so the outputs read zero whenever nothing is buffered
  assign m_rvalid     = ~empty;
  assign m_rid        = empty ? '0 : head.id;
  assign m_rdata      = empty ? '0 : head.data;
  assign m_rresp      = empty ? '0 : head.resp;
  assign m_rlast      = empty ? 1'b0 : head.last;
  assign protocol_err = perr_q;

  // Pointer and occupancy next state; pointers wrap naturally (power-of-two depth)
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Burst tracker: a mismatching beat is still buffered and its s_rlast still steers the FSM
  always_comb begin
    state_d    = state_q;
    burst_id_d = burst_id_q;
    perr_d     = perr_q;
    if (push) begin
      case (state_q)
        ST_IDLE: begin
          if (!s_rlast) begin
            state_d    = ST_BURST;
            burst_id_d = s_rid;
          end
        end
        default: begin
          if (s_rid != burst_id_q) perr_d = 1'b1;
          if (s_rlast) state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control state; reset discards buffered beats by clearing the pointers/occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      burst_id_q <= '0;
      perr_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      burst_id_q <= burst_id_d;
      perr_q     <= perr_d;
    end
  end

  // Beat storage; contents need no reset since empty gates the outputs
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_beat;
  end

`ifdef RSP_ERR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of accepted non-OKAY beats
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && (s_rresp != 2'b00) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_response_id_restore_unit.sv
// Directed bench for response_id_restore_unit. Inputs change on the falling edge,
// outputs are sampled 1 time unit later; the DUT acts on the rising edge.
// Build with RSP_ERR_COUNT_EN defined to also exercise the error counter.
module tb_response_id_restore_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_rvalid = 1'b0;
  logic        s_rready;
  logic [3:0]  s_rid = '0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = '0;
  logic        s_rlast = 1'b0;
  logic [3:0]  unique_id_to_free;
  logic        free_req;
  logic [3:0]  restored_id;
  logic        m_rvalid;
  logic        m_rready = 1'b0;
  logic [3:0]  m_rid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        protocol_err;
`ifdef RSP_ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Allocator model: fixed unique -> original ID table
  always_comb begin
    case (unique_id_to_free)
      4'd3:    restored_id = 4'd9;
      4'd5:    restored_id = 4'd2;
      4'd1:    restored_id = 4'd7;
      4'd4:    restored_id = 4'd6;
      default: restored_id = 4'd0;
    endcase
  end

  response_id_restore_unit #(.ID_WIDTH(4), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .unique_id_to_free(unique_id_to_free), .free_req(free_req), .restored_id(restored_id),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .protocol_err(protocol_err)
`ifdef RSP_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (s_rready !== 1'b1)     begin n_bad++; $display("FAIL reset_s_rready got %b want 1", s_rready); end
    n_cmp++; if (m_rvalid !== 1'b0)     begin n_bad++; $display("FAIL reset_m_rvalid got %b want 0", m_rvalid); end
    n_cmp++; if (m_rid !== 4'd0)        begin n_bad++; $display("FAIL reset_m_rid got %0d want 0", m_rid); end
    n_cmp++; if (m_rdata !== 32'd0)     begin n_bad++; $display("FAIL reset_m_rdata got %h want 0", m_rdata); end
    n_cmp++; if (m_rresp !== 2'd0 || m_rlast !== 1'b0) begin n_bad++; $display("FAIL reset_resp_last got %b/%b want 0/0", m_rresp, m_rlast); end
    n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL reset_perr got %b want 0", protocol_err); end
    n_cmp++; if (free_req !== 1'b0)     begin n_bad++; $display("FAIL reset_free got %b want 0", free_req); end
`ifdef RSP_ERR_COUNT_EN
    n_cmp++; if (err_count !== 8'd0)    begin n_bad++; $display("FAIL reset_errcnt got %0d want 0", err_count); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    s_rvalid = 1'b1; s_rid = 4'd3; s_rdata = 32'h55; s_rresp = 2'd0; s_rlast = 1'b1; m_rready = 1'b1;
    #1;
    n_cmp++; if (free_req !== 1'b1)           begin n_bad++; $display("FAIL single_free got %b want 1", free_req); end
    n_cmp++; if (unique_id_to_free !== 4'd3)  begin n_bad++; $display("FAIL single_uid got %0d want 3", unique_id_to_free); end
    n_cmp++; if (m_rvalid !== 1'b0)           begin n_bad++; $display("FAIL single_latency got %b want 0", m_rvalid); end
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    n_cmp++; if (m_rvalid !== 1'b1 || m_rid !== 4'd9 || m_rlast !== 1'b1 || m_rdata !== 32'h55)
      begin n_bad++; $display("FAIL single_out got v%b id%0d l%b d%h want v1 id9 l1 d55", m_rvalid, m_rid, m_rlast, m_rdata); end
    n_cmp++; if (free_req !== 1'b0)           begin n_bad++; $display("FAIL single_free_idle got %b want 0", free_req); end
    @(negedge clk);
    #1;
    n_cmp++; if (m_rvalid !== 1'b0)           begin n_bad++; $display("FAIL single_drained got %b want 0", m_rvalid); end
  endtask

  task automatic test_burst();
    int nfree = 0;
    int nout  = 0;
    m_rready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (cyc < 4) begin
        s_rvalid = 1'b1; s_rid = 4'd5; s_rdata = 32'hA0 + cyc; s_rresp = 2'd0; s_rlast = (cyc == 3);
      end else begin
        s_rvalid = 1'b0; s_rlast = 1'b0;
      end
      #1;
      n_cmp++; if (free_req !== (cyc == 3)) begin n_bad++; $display("FAIL burst_free cyc%0d got %b want %b", cyc, free_req, cyc == 3); end
      if (free_req) nfree++;
      if (m_rvalid) begin
        n_cmp++; if (m_rid !== 4'd2 || m_rdata !== 32'hA0 + nout)
          begin n_bad++; $display("FAIL burst_data got id%0d d%h want id2 d%h", m_rid, m_rdata, 32'hA0 + nout); end
        nout++;
      end
    end
    n_cmp++; if (nfree != 1) begin n_bad++; $display("FAIL burst_nfree got %0d want 1", nfree); end
    n_cmp++; if (nout != 4)  begin n_bad++; $display("FAIL burst_nout got %0d want 4", nout); end
    // FSM must be IDLE: a different-ID single beat must not raise the error
    @(negedge clk);
    s_rvalid = 1'b1; s_rid = 4'd3; s_rdata = 32'h77; s_rlast = 1'b1;
    @(negedge clk);
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    n_cmp++; if (protocol_err !== 1'b0 || m_rid !== 4'd9 || m_rdata !== 32'h77)
      begin n_bad++; $display("FAIL burst_idle got perr%b id%0d d%h want perr0 id9 d77", protocol_err, m_rid, m_rdata); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int acc = 0;
    m_rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_rvalid = 1'b1; s_rid = 4'd3; s_rlast = 1'b1; s_rresp = 2'd0; s_rdata = 32'hB0 + acc;
      #1;
      n_cmp++; if (s_rready !== (acc < 4)) begin n_bad++; $display("FAIL bp_rready i%0d got %b want %b", i, s_rready, acc < 4); end
      if (s_rready) acc++;
    end
    n_cmp++; if (acc != 4) begin n_bad++; $display("FAIL bp_accepts got %0d want 4", acc); end
    @(negedge clk);
    m_rready = 1'b1;
    #1;
    n_cmp++; if (s_rready !== 1'b0 || m_rdata !== 32'hB0)
      begin n_bad++; $display("FAIL bp_full_pop got rdy%b d%h want rdy0 dB0", s_rready, m_rdata); end
    @(negedge clk);
    m_rready = 1'b0; s_rvalid = 1'b0;
    #1;
    n_cmp++; if (s_rready !== 1'b1 || m_rdata !== 32'hB1)
      begin n_bad++; $display("FAIL bp_after_pop got rdy%b d%h want rdy1 dB1", s_rready, m_rdata); end
    @(negedge clk);
    #1;
    n_cmp++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hB1)
      begin n_bad++; $display("FAIL bp_stable got v%b d%h want v1 dB1", m_rvalid, m_rdata); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m_rready = 1'b1;
      #1;
      n_cmp++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hB1 + k)
        begin n_bad++; $display("FAIL bp_drain got v%b d%h want v1 d%h", m_rvalid, m_rdata, 32'hB1 + k); end
    end
    @(negedge clk);
    m_rready = 1'b0;
    #1;
    n_cmp++; if (m_rvalid !== 1'b0) begin n_bad++; $display("FAIL bp_empty got %b want 0", m_rvalid); end
  endtask

  task automatic test_protocol_err();
    logic [3:0] ids  [3] = '{4'd1, 4'd1, 4'd4};
    logic [3:0] orig [3] = '{4'd7, 4'd7, 4'd6};
    int nout = 0;
    m_rready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (cyc < 3) begin
        s_rvalid = 1'b1; s_rid = ids[cyc]; s_rdata = 32'hC0 + cyc; s_rlast = (cyc == 2);
      end else begin
        s_rvalid = 1'b0; s_rlast = 1'b0;
      end
      #1;
      n_cmp++; if (protocol_err !== (cyc == 3)) begin n_bad++; $display("FAIL perr_flag cyc%0d got %b want %b", cyc, protocol_err, cyc == 3); end
      if (m_rvalid) begin
        n_cmp++; if (m_rid !== orig[nout] || m_rdata !== 32'hC0 + nout)
          begin n_bad++; $display("FAIL perr_data got id%0d d%h want id%0d d%h", m_rid, m_rdata, orig[nout], 32'hC0 + nout); end
        nout++;
      end
    end
    n_cmp++; if (nout != 3) begin n_bad++; $display("FAIL perr_nout got %0d want 3", nout); end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL perr_sticky got %b want 1", protocol_err); end
  endtask

  task automatic test_reset_mid_burst();
    m_rready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_rvalid = 1'b1; s_rid = 4'd1; s_rdata = 32'hD0 + i; s_rlast = 1'b0;
    end
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    n_cmp++; if (m_rvalid !== 1'b1) begin n_bad++; $display("FAIL rmid_buffered got %b want 1", m_rvalid); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (m_rvalid !== 1'b0 || s_rready !== 1'b1 || protocol_err !== 1'b0 || m_rdata !== 32'd0)
      begin n_bad++; $display("FAIL rmid_async got v%b rdy%b perr%b d%h want v0 rdy1 perr0 d0", m_rvalid, s_rready, protocol_err, m_rdata); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    s_rvalid = 1'b1; s_rid = 4'd4; s_rdata = 32'hE0; s_rlast = 1'b1; m_rready = 1'b1;
    @(negedge clk);
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    n_cmp++; if (protocol_err !== 1'b0 || m_rvalid !== 1'b1 || m_rid !== 4'd6 || m_rdata !== 32'hE0)
      begin n_bad++; $display("FAIL rmid_after got perr%b v%b id%0d d%h want perr0 v1 id6 dE0", protocol_err, m_rvalid, m_rid, m_rdata); end
    @(negedge clk);
  endtask

`ifdef RSP_ERR_COUNT_EN
  task automatic test_err_count();
    m_rready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      s_rvalid = 1'b1; s_rid = 4'd3; s_rlast = 1'b1; s_rresp = 2'b10; s_rdata = i;
      #1;
      if (i == 3) begin
        n_cmp++; if (err_count !== 8'd3) begin n_bad++; $display("FAIL errcnt_mid got %0d want 3", err_count); end
      end
    end
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    n_cmp++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL errcnt_sat got %0d want 255", err_count); end
    @(negedge clk);
    s_rvalid = 1'b1; s_rresp = 2'b00;
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    n_cmp++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL errcnt_okay got %0d want 255", err_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_protocol_err();
    test_reset_mid_burst();
`ifdef RSP_ERR_COUNT_EN
    test_err_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
